pwm_btn_cond: RTL and testbench

Four-channel push-button conditioner that sits directly upstream of the PWM controller (pwm_in_sync). It takes raw, asynchronous, bouncing button levels for increase/decrease duty and increase/decrease frequency. It produces clean single-clock-cycle command pulses, with optional hold-to-repeat. It guarantees the controller never sees a metastable, bounced or contradictory (inc+dec same cycle) command.

---
 rtl/pwm_pkg.sv | 36 +++
 rtl/btn_debounce.sv | 139 +++++++++++++
 rtl/pwm_btn_cond_chk.sv | 22 ++
 rtl/pwm_btn_cond.sv | 71 +++++++
 tb/tb_pwm_btn_cond.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM button front end and the PWM controller benches.
package pwm_pkg;

    // Bit positions of the four command channels on btn_i / pulse_o / level_o
    localparam int unsigned BTN_INC_DUTY = 0;
    localparam int unsigned BTN_DEC_DUTY = 1;
    localparam int unsigned BTN_INC_FREQ = 2;
    localparam int unsigned BTN_DEC_FREQ = 3;
    localparam int unsigned BTN_NUM      = 4;

    // Default timing, in clock cycles
    localparam int DEF_DEB_CNT    = 200;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_RPT_EN     = 1;
    localparam int DEF_RPT_DELAY  = 5000;
    localparam int DEF_RPT_PERIOD = 1000;

    // Hold-to-repeat phase: waiting for the first repeat, or in the periodic phase
    typedef enum logic [0:0] {
        PH_DELAY  = 1'b0,
        PH_PERIOD = 1'b1
    } rpt_phase_e;

    // Contradictory commands of one pair cancel each other; a lone command passes
    function automatic logic [1:0] pair_excl(input logic [1:0] raw);
        logic [1:0] res;
        case (raw)
            2'b11:   res = 2'b00;
            2'b01:   res = 2'b01;
            2'b10:   res = 2'b10;
            default: res = 2'b00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, press edge and
// hold-to-repeat timer. raw_pulse is high for one cycle per press or repeat.
module btn_debounce
    import pwm_pkg::*;
#(
    parameter int DEB_CNT    = DEF_DEB_CNT,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int RPT_EN     = DEF_RPT_EN,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic raw_pulse
);

    // Repeat spacing is forced to at least 2 cycles so a pulse can never follow a pulse
    localparam int RPT_DELAY_EFF  = (RPT_DELAY  < 2) ? 2 : RPT_DELAY;
    localparam int RPT_PERIOD_EFF = (RPT_PERIOD < 2) ? 2 : RPT_PERIOD;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(RPT_DELAY_EFF - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(RPT_PERIOD_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    // Counters stick at all-ones rather than wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        if (v == CNT_MAX) begin
            res = v;
        end else begin
            res = v + CNT_W'(1);
        end
        return res;
    endfunction

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             pulse_r;
    logic [CNT_W-1:0] deb_cnt_r;
    logic [CNT_W-1:0] rpt_cnt_r;
    rpt_phase_e       phase_r;

    logic             level_s;
    logic             pulse_s;
    logic [CNT_W-1:0] deb_cnt_s;
    logic [CNT_W-1:0] rpt_cnt_s;
    rpt_phase_e       phase_s;

    // State register: synchroniser, accepted level, counters, phase and pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            level_r   <= 1'b0;
            pulse_r   <= 1'b0;
            deb_cnt_r <= CNT_ZERO;
            rpt_cnt_r <= CNT_ZERO;
            phase_r   <= PH_DELAY;
        end else begin
            sync1_r   <= btn;
            sync2_r   <= sync1_r;
            level_r   <= level_s;
            pulse_r   <= pulse_s;
            deb_cnt_r <= deb_cnt_s;
            rpt_cnt_r <= rpt_cnt_s;
            phase_r   <= phase_s;
        end
    end

    // Next state: debounce acceptance, press edge and repeat scheduling
    always_comb begin
        level_s   = level_r;
        deb_cnt_s = CNT_ZERO;
        pulse_s   = 1'b0;
        rpt_cnt_s = CNT_ZERO;
        phase_s   = PH_DELAY;

        // A sample equal to the accepted level restarts the count
        if (sync2_r == level_r) begin
            deb_cnt_s = CNT_ZERO;
        end else if (deb_cnt_r >= DEB_LAST) begin
            level_s   = sync2_r;
            deb_cnt_s = CNT_ZERO;
        end else begin
            deb_cnt_s = sat_inc(deb_cnt_r);
        end

        // Released (or releasing this cycle): timer idle, no pulse
        if (!level_s) begin
            pulse_s   = 1'b0;
            rpt_cnt_s = CNT_ZERO;
            phase_s   = PH_DELAY;
        end else if (!level_r) begin
            // Press edge: issue the press pulse and start the repeat timer
            pulse_s   = 1'b1;
            rpt_cnt_s = CNT_ZERO;
            phase_s   = PH_DELAY;
        end else if (RPT_EN != 0) begin
            case (phase_r)
                PH_DELAY: begin
                    if (rpt_cnt_r >= DELAY_LAST) begin
                        pulse_s   = 1'b1;
                        rpt_cnt_s = CNT_ZERO;
                        phase_s   = PH_PERIOD;
                    end else begin
                        rpt_cnt_s = sat_inc(rpt_cnt_r);
                        phase_s   = PH_DELAY;
                    end
                end
                PH_PERIOD: begin
                    if (rpt_cnt_r >= PERIOD_LAST) begin
                        pulse_s   = 1'b1;
                        rpt_cnt_s = CNT_ZERO;
                        phase_s   = PH_PERIOD;
                    end else begin
                        rpt_cnt_s = sat_inc(rpt_cnt_r);
                        phase_s   = PH_PERIOD;
                    end
                end
                default: begin
                    rpt_cnt_s = CNT_ZERO;
                    phase_s   = PH_DELAY;
                end
            endcase
        end else begin
            rpt_cnt_s = CNT_ZERO;
            phase_s   = PH_DELAY;
        end
    end

    assign level     = level_r;
    assign raw_pulse = pulse_r;

endmodule

// File: rtl/pwm_btn_cond_chk.sv
// Configuration checker: rejects parameter sets the counters cannot represent.
module pwm_btn_cond_chk #(
    parameter int DEB_CNT    = 200,
    parameter int CNT_W      = 16,
    parameter int RPT_DELAY  = 5000,
    parameter int RPT_PERIOD = 1000
) ();

    localparam longint CNT_LIMIT = (64'sd1 <<< CNT_W) - 64'sd1;

    if (DEB_CNT < 2) begin : g_deb_small
        $error("pwm_btn_cond: DEB_CNT must be at least 2");
    end
    if (RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_rpt_small
        $error("pwm_btn_cond: RPT_DELAY and RPT_PERIOD must be at least 1");
    end
    if (longint'(DEB_CNT) > CNT_LIMIT || longint'(RPT_DELAY) > CNT_LIMIT ||
        longint'(RPT_PERIOD) > CNT_LIMIT) begin : g_cnt_range
        $error("pwm_btn_cond: timing parameter exceeds CNT_W counter range");
    end

endmodule

// File: rtl/pwm_btn_cond.sv
// Four-channel button conditioner feeding the PWM controller: debounced levels
// plus one-cycle command pulses with contradictory pairs cancelled.
module pwm_btn_cond
    import pwm_pkg::*;
#(
    parameter int DEB_CNT    = DEF_DEB_CNT,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int RPT_EN     = DEF_RPT_EN,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_i,
    output logic [3:0] pulse_o,
    output logic [3:0] level_o
);

    logic [3:0] level_s;
    logic [3:0] raw_pulse_s;
    logic [3:0] pulse_nxt_s;
    logic [3:0] pulse_r;
    logic [3:0] level_r;

    for (genvar g = 0; g < 4; g++) begin : g_ch
        btn_debounce #(
            .DEB_CNT   (DEB_CNT),
            .CNT_W     (CNT_W),
            .RPT_EN    (RPT_EN),
            .RPT_DELAY (RPT_DELAY),
            .RPT_PERIOD(RPT_PERIOD)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .btn      (btn_i[g]),
            .level    (level_s[g]),
            .raw_pulse(raw_pulse_s[g])
        );
    end

    pwm_btn_cond_chk #(
        .DEB_CNT   (DEB_CNT),
        .CNT_W     (CNT_W),
        .RPT_DELAY (RPT_DELAY),
        .RPT_PERIOD(RPT_PERIOD)
    ) u_chk ();

    // Pair exclusion: duty inc/dec cancel, freq inc/dec cancel, cross pairs pass
    always_comb begin
        pulse_nxt_s = 4'b0000;
        {pulse_nxt_s[BTN_DEC_DUTY], pulse_nxt_s[BTN_INC_DUTY]} =
            pair_excl({raw_pulse_s[BTN_DEC_DUTY], raw_pulse_s[BTN_INC_DUTY]});
        {pulse_nxt_s[BTN_DEC_FREQ], pulse_nxt_s[BTN_INC_FREQ]} =
            pair_excl({raw_pulse_s[BTN_DEC_FREQ], raw_pulse_s[BTN_INC_FREQ]});
    end

    // Output register: keeps pulse_o and level_o glitch-free and aligned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse_r <= 4'b0000;
            level_r <= 4'b0000;
        end else begin
            pulse_r <= pulse_nxt_s;
            level_r <= level_s;
        end
    end

    assign pulse_o = pulse_r;
    assign level_o = level_r;

endmodule

// File: tb/tb_pwm_btn_cond.sv
// Bench for pwm_btn_cond: directed scenarios plus random button activity,
// checked every cycle against a window/arithmetic reference model.
module tb_pwm_btn_cond;

    localparam int DEB = 4;
    localparam int CW  = 16;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [3:0] pulse_o;
    logic [3:0] level_o;

    pwm_btn_cond #(
        .DEB_CNT   (DEB),
        .CNT_W     (CW),
        .RPT_EN    (1),
        .RPT_DELAY (RD),
        .RPT_PERIOD(RP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn),
        .pulse_o(pulse_o),
        .level_o(level_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    // Reference model state
    logic [3:0] hist[$];        // button value sampled at each clock edge
    logic [3:0] m_level;        // accepted level after the latest edge
    logic [3:0] m_raw;          // pre-exclusion pulses after the latest edge
    logic [3:0] exp_pulse;
    logic [3:0] exp_level;
    int         press_at[4];

    // Observation logs
    int         pulse_log[4][$];
    int         lvl_fall[4][$];
    logic [3:0] prev_lvl;
    logic [3:0] prev_pulse;
    bit         saw_0101;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d got=%b exp=%b", tag, edge_n, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        total++;
        assert (got == exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] excl(input logic [3:0] raw);
        logic [3:0] r;
        r = raw;
        if (raw[0] && raw[1]) r[1:0] = 2'b00;
        if (raw[2] && raw[3]) r[3:2] = 2'b00;
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_back(4'b0000);
        m_level    = 4'b0000;
        m_raw      = 4'b0000;
        exp_pulse  = 4'b0000;
        exp_level  = 4'b0000;
        prev_lvl   = 4'b0000;
        prev_pulse = 4'b0000;
    endtask

    task automatic clear_logs();
        for (int c = 0; c < 4; c++) begin
            pulse_log[c].delete();
            lvl_fall[c].delete();
        end
        saw_0101 = 1'b0;
    endtask

    // Level flips once DEB consecutive samples (delayed by the 2-flop
    // synchroniser) all disagree with it; pulses on press and on the
    // repeat schedule measured from the press edge.
    task automatic model_edge();
        logic [3:0] nl;
        logic [3:0] nr;
        int         n;
        int         d;
        bit         diff;
        edge_n++;
        exp_level = m_level;
        exp_pulse = excl(m_raw);
        hist.push_back(btn);
        n  = hist.size();
        nl = m_level;
        nr = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            diff = 1'b1;
            for (int k = 2; k <= DEB + 1; k++) begin
                if (hist[n-1-k][c] == m_level[c]) diff = 1'b0;
            end
            if (diff) nl[c] = ~m_level[c];
            if (nl[c]) begin
                if (!m_level[c]) begin
                    nr[c] = 1'b1;
                    press_at[c] = edge_n;
                end else begin
                    d = edge_n - press_at[c];
                    if (d == RD || (d > RD && ((d - RD) % RP) == 0)) nr[c] = 1'b1;
                end
            end
        end
        m_level = nl;
        m_raw   = nr;
    endtask

    task automatic step(input logic [3:0] b);
        btn = b;
        @(posedge clk);
        model_edge();
        #1;
        chk("pulse", pulse_o, exp_pulse);
        chk("level", level_o, exp_level);
        chk("no_back_to_back", pulse_o & prev_pulse, 4'b0000);
        for (int c = 0; c < 4; c++) begin
            if (pulse_o[c]) pulse_log[c].push_back(edge_n);
            if (prev_lvl[c] && !level_o[c]) lvl_fall[c].push_back(edge_n);
        end
        if (pulse_o == 4'b0101) saw_0101 = 1'b1;
        prev_lvl   = level_o;
        prev_pulse = pulse_o;
    endtask

    // Assert reset between clock edges, hold it over two edges, release mid-cycle
    task automatic async_reset(input logic [3:0] b);
        btn = b;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_pulse", pulse_o, 4'b0000);
        chk("rst_async_level", level_o, 4'b0000);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_pulse", pulse_o, 4'b0000);
        chk("rst_hold_level", level_o, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int         e0;
        int         r0;
        int         hold_off[6];
        logic [3:0] cur;

        // Power-on reset
        model_reset();
        clear_logs();
        rst = 1'b0;
        btn = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pulse", pulse_o, 4'b0000);
        chk("reset_level", level_o, 4'b0000);
        @(negedge clk);
        rst = 1'b1;

        // Clean press and release on inc_duty
        clear_logs();
        e0 = edge_n + 1;
        repeat (10) step(4'b0001);
        r0 = edge_n + 1;
        repeat (12) step(4'b0000);
        chk_int("press_count", pulse_log[0].size(), 1);
        chk_int("press_latency", (pulse_log[0].size() > 0) ? pulse_log[0][0] - e0 : -1, 6);
        chk_int("release_latency", (lvl_fall[0].size() > 0) ? lvl_fall[0][0] - r0 : -1, 6);

        // Bouncing inc_freq
        clear_logs();
        repeat (2) step(4'b0100);
        repeat (2) step(4'b0000);
        repeat (2) step(4'b0100);
        repeat (2) step(4'b0000);
        e0 = edge_n + 1;
        repeat (12) step(4'b0100);
        repeat (10) step(4'b0000);
        chk_int("bounce_count", pulse_log[2].size(), 1);
        chk_int("bounce_latency", (pulse_log[2].size() > 0) ? pulse_log[2][0] - e0 : -1, DEB + 2);

        // Hold-to-repeat on dec_duty
        clear_logs();
        e0 = edge_n + 1;
        repeat (60) step(4'b0010);
        repeat (12) step(4'b0000);
        hold_off = '{6, 26, 34, 42, 50, 58};
        chk_int("repeat_count", pulse_log[1].size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk_int("repeat_offset",
                    (pulse_log[1].size() > i) ? pulse_log[1][i] - e0 : -1, hold_off[i]);
        end

        // Contradictory duty pair, then a legal cross-pair combination
        clear_logs();
        repeat (40) step(4'b0011);
        repeat (12) step(4'b0000);
        chk_int("pair_suppressed", pulse_log[0].size() + pulse_log[1].size(), 0);
        repeat (10) step(4'b0101);
        repeat (10) step(4'b0000);
        chk_int("cross_pair_0101", int'(saw_0101), 1);

        // Reset while dec_freq is held
        repeat (10) step(4'b1000);
        async_reset(4'b1000);
        clear_logs();
        e0 = edge_n + 1;
        repeat (12) step(4'b1000);
        repeat (8) step(4'b0000);
        chk_int("post_reset_count", pulse_log[3].size(), 1);
        chk_int("post_reset_latency", (pulse_log[3].size() > 0) ? pulse_log[3][0] - e0 : -1, DEB + 2);

        // Random button activity with one mid-run reset
        cur = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 7) == 0) cur[c] = ~cur[c];
            end
            if (i == 300) async_reset(cur);
            step(cur);
        end
        repeat (30) step(4'b0000);
        chk("final_idle_level", level_o, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
